// File: rtl/mul_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_pkg;

  // Sequencer states: wait for a request, compute the product, hold the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int MUL_OP_W  = 16;
  localparam int MUL_RES_W = 2 * MUL_OP_W;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the priority pointer lives in the parent.
// Latency: 0 cycles.
// Backpressure: none; grant follows req combinationally.
//   req     : per-requester request vector
//   ptr     : index with highest priority this cycle
//   gnt     : one-hot grant (all zero when nothing requests)
//   gnt_idx : index of the granted requester (0 when nothing requests)
//   any_req : at least one request is present
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            any_req
);

  always_comb begin
    logic [ID_W-1:0] idx;
    logic            found;
    idx     = '0;
    found   = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    any_req = |req;
    // Scan ptr, ptr+1, ... modulo N; the first asserted request wins.
    for (int i = 0; i < N; i++) begin
      idx = ID_W'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/shared_mul.sv
// Shared combinational unsigned multiplier datapath.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller registers the product.
//   a, b : W-bit unsigned operands
//   p    : 2*W-bit full-width product
module shared_mul #(
  parameter int W = 16
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  assign p = a * b;

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one 16x16 unsigned multiplier between N_REQ requesters, round-robin.
// Latency: grant at T, resp_valid at T+2; minimum issue interval 3 cycles.
// Backpressure: result held in RESP until resp_ready; no grants until then.
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid/req_ready   : per-requester operand handshake (ready is one-hot)
//   req_a, req_b          : packed operands, requester i at [i*OP_W +: OP_W]
//   resp_valid/resp_ready : result handshake; resp_id tags the owner
//   resp_res              : registered full-width product
//   busy                  : sequencer is not idle
module mul_share_arbiter
  import mul_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int OP_W  = MUL_OP_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*OP_W-1:0] req_a,
  input  logic [N_REQ*OP_W-1:0] req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [2*OP_W-1:0]     resp_res,
  input  logic                  resp_ready,
  output logic                  busy
);

  localparam int RES_W = 2 * OP_W;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   ptr_nxt;
  logic [ID_W-1:0]   cur_id;
  logic [OP_W-1:0]   op_a, op_b;
  logic [RES_W-1:0]  product;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              any_req;
  logic              grant_fire;

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  shared_mul #(
    .W (OP_W)
  ) u_mul (
    .a (op_a),
    .b (op_b),
    .p (product)
  );

  // Gated by rst_n so a requester is never told it was accepted on a cycle
  // whose edge is about to discard the latch.
  assign grant_fire = rst_n && (state == IDLE) && any_req;
  assign req_ready  = grant_fire ? gnt : '0;
  assign busy       = (state != IDLE);

  // Pointer moves to the slot after the winner, wrapping at N_REQ-1.
  assign ptr_nxt = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur_id     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_res   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_fire) begin
        op_a   <= req_a[gnt_idx*OP_W +: OP_W];
        op_b   <= req_b[gnt_idx*OP_W +: OP_W];
        cur_id <= gnt_idx;
        rr_ptr <= ptr_nxt;
      end
      if (state == CALC) begin
        resp_res   <= product;
        resp_id    <= cur_id;
        resp_valid <= 1'b1;
      end
      if (state == RESP && resp_ready) resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [31:0] resp_res;
  logic        resp_ready;
  logic        busy;

  always #5 clk = ~clk;

  mul_share_arbiter #(.N_REQ(4), .ID_W(2), .OP_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_res   (resp_res),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [63:0] a;
    logic [63:0] b;
    logic        rdy;
    logic [3:0]  ereq;
    logic        evld;
    logic [1:0]  eid;
    logic [31:0] eres;
    logic        ebusy;
    logic        chk_dat;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] pk(logic [15:0] x3, logic [15:0] x2,
                                     logic [15:0] x1, logic [15:0] x0);
    return {x3, x2, x1, x0};
  endfunction

  function automatic vec_t mk(logic r, logic [3:0] v, logic [63:0] a, logic [63:0] b,
                              logic rdy, logic [3:0] ereq, logic evld, logic [1:0] eid,
                              logic [31:0] eres, logic ebusy, logic cd);
    vec_t t;
    t.rst_n = r; t.valid = v; t.a = a; t.b = b; t.rdy = rdy;
    t.ereq = ereq; t.evld = evld; t.eid = eid; t.eres = eres;
    t.ebusy = ebusy; t.chk_dat = cd || evld;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] ra, rb, sa, sb, ba, bb, a5, b5, wa, wb;
    int grants, last, lat;

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    tick();

    // Reset held two cycles with all requesters asking.
    ra = pk(16'd4, 16'd3, 16'd2, 16'd1);
    rb = pk(16'd40, 16'd30, 16'd20, 16'd10);
    tbl.push_back(mk(0, 4'hF, ra, rb, 1, 4'h0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'hF, ra, rb, 1, 4'h0, 0, 0, 0, 0, 1));
    // Round robin 0,1,2,3,0 every 3 cycles; products 10,40,90,160.
    for (int k = 0; k < 5; k++) begin
      logic [3:0]  g;
      logic [31:0] p;
      g = 4'b0001 << (k % 4);
      p = (32'(k % 4) + 1) * (32'(k % 4) + 1) * 10;
      tbl.push_back(mk(1, 4'hF, ra, rb, 1, g,    0, 0,         0, 0, 0));
      tbl.push_back(mk(1, 4'hF, ra, rb, 1, 4'h0, 0, 0,         0, 1, 0));
      tbl.push_back(mk(1, 4'hF, ra, rb, 1, 4'h0, 1, 2'(k % 4), p, 1, 0));
    end
    tbl.push_back(mk(1, 4'h0, ra, rb, 1, 4'h0, 0, 0, 0, 0, 0));
    // Single request from 2: 3*5.
    sa = pk(16'd0, 16'd3, 16'd0, 16'd0);
    sb = pk(16'd0, 16'd5, 16'd0, 16'd0);
    tbl.push_back(mk(1, 4'h4, sa, sb, 1, 4'h4, 0, 0, 0,     0, 0));
    tbl.push_back(mk(1, 4'h0, sa, sb, 1, 4'h0, 0, 0, 0,     1, 0));
    tbl.push_back(mk(1, 4'h0, sa, sb, 1, 4'h0, 1, 2, 32'hF, 1, 0));
    tbl.push_back(mk(1, 4'h0, sa, sb, 1, 4'h0, 0, 0, 0,     0, 0));
    // Backpressure on 0xFFFF*0xFFFF; requester 1 waits.
    ba = pk(16'd0, 16'd0, 16'd7, 16'hFFFF);
    bb = pk(16'd0, 16'd0, 16'd9, 16'hFFFF);
    tbl.push_back(mk(1, 4'h1, ba, bb, 0, 4'h1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h2, ba, bb, 0, 4'h0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, 4'h2, ba, bb, 0, 4'h0, 1, 0, 32'hFFFE0001, 1, 0));
    tbl.push_back(mk(1, 4'h2, ba, bb, 1, 4'h0, 1, 0, 32'hFFFE0001, 1, 0));
    tbl.push_back(mk(1, 4'h2, ba, bb, 1, 4'h2, 0, 0, 0,     0, 0));
    tbl.push_back(mk(1, 4'h0, ba, bb, 1, 4'h0, 0, 0, 0,     1, 0));
    tbl.push_back(mk(1, 4'h0, ba, bb, 1, 4'h0, 1, 1, 32'd63, 1, 0));
    tbl.push_back(mk(1, 4'h0, ba, bb, 1, 4'h0, 0, 0, 0,     0, 0));
    // Reset during CALC: op abandoned, rr_ptr back to 0 (req 0 beats req 3).
    a5 = pk(16'h1234, 16'd0, 16'd0, 16'd5);
    b5 = pk(16'h0010, 16'd0, 16'd0, 16'd6);
    tbl.push_back(mk(1, 4'h1, a5, b5, 1, 4'h1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h0, a5, b5, 1, 4'h0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'h9, a5, b5, 1, 4'h1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'h8, a5, b5, 1, 4'h0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'h8, a5, b5, 1, 4'h0, 1, 0, 32'd30, 1, 0));
    tbl.push_back(mk(1, 4'h8, a5, b5, 1, 4'h8, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, a5, b5, 1, 4'h0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'h0, a5, b5, 1, 4'h0, 1, 3, 32'h12340, 1, 0));
    // Withdrawn request: 1 and 3 valid from ptr 0, 3 drops; then ptr must be 2.
    wa = pk(16'd0, 16'h8000, 16'h0100, 16'd0);
    wb = pk(16'd0, 16'd2,    16'h0100, 16'd0);
    tbl.push_back(mk(1, 4'hA, wa, wb, 1, 4'h2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h8, wa, wb, 1, 4'h0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'h0, wa, wb, 1, 4'h0, 1, 1, 32'h10000, 1, 0));
    tbl.push_back(mk(1, 4'h0, wa, wb, 1, 4'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'hC, wa, wb, 1, 4'h4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, wa, wb, 1, 4'h0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'h0, wa, wb, 1, 4'h0, 1, 2, 32'h10000, 1, 0));
    tbl.push_back(mk(1, 4'h0, wa, wb, 1, 4'h0, 0, 0, 0, 0, 0));

    foreach (tbl[k]) begin
      rst_n = tbl[k].rst_n; req_valid = tbl[k].valid;
      req_a = tbl[k].a; req_b = tbl[k].b; resp_ready = tbl[k].rdy;
      #1;
      chk($sformatf("v%0d req_ready", k), 32'(req_ready), 32'(tbl[k].ereq));
      chk($sformatf("v%0d resp_valid", k), 32'(resp_valid), 32'(tbl[k].evld));
      chk($sformatf("v%0d busy", k), 32'(busy), 32'(tbl[k].ebusy));
      if (tbl[k].chk_dat) begin
        chk($sformatf("v%0d resp_id", k), 32'(resp_id), 32'(tbl[k].eid));
        chk($sformatf("v%0d resp_res", k), resp_res, tbl[k].eres);
      end
      tick();
    end

    // Persistent single requester (3, pointer already at 3): grant every 3 cycles.
    req_valid = 4'b1000; resp_ready = 1'b1;
    req_a = pk(16'd2, 16'd0, 16'd0, 16'd0); req_b = pk(16'd3, 16'd0, 16'd0, 16'd0);
    grants = 0; last = -1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready != 4'b0000) begin
        chk("persist grant", 32'(req_ready), 32'h8);
        if (grants > 0) chk("persist interval", 32'(c - last), 32'd3);
        grants++;
        last = c;
      end
      tick();
    end
    chk("persist count", 32'(grants), 32'd4);
    req_valid = 4'b0000;
    for (int i = 0; i < 5 && busy; i++) tick();
    chk("drain idle", 32'(busy), 32'd0);

    // Latency T+2, then reset while holding a result in RESP.
    req_valid = 4'b0001;
    req_a = pk(16'd0, 16'd0, 16'd0, 16'h00FF); req_b = pk(16'd0, 16'd0, 16'd0, 16'h0101);
    #1;
    chk("lat grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000; resp_ready = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 6) begin
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'd2);
    chk("lat res", resp_res, 32'hFFFF);
    tick(); tick();
    chk("hold valid", 32'(resp_valid), 32'd1);
    chk("hold res", resp_res, 32'hFFFF);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst resp_res", resp_res, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
